// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the mem_arbiter front end.
package mem_arb_pkg;

   localparam int MEM_AW   = 16;
   localparam int MEM_DW   = 32;
   localparam int WORD_LSB = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_e;

endpackage

// File: rtl/mem_byte_merge.sv
// Byte-lane merge of a freshly read word with store data under a strobe.
module mem_byte_merge
   import mem_arb_pkg::*;
(
   input  logic [MEM_DW-1:0]   old_word,
   input  logic [MEM_DW-1:0]   new_word,
   input  logic [MEM_DW/8-1:0] strb,
   output logic [MEM_DW-1:0]   merged
);

   // Each strobed lane takes the store byte, the rest keep the memory byte.
   always_comb begin
      merged = old_word;
      for (int n = 0; n < MEM_DW/8; n++) begin
         if (strb[n]) merged[8*n +: 8] = new_word[8*n +: 8];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) front end for a single-port 64K x 32 memory
// with 1-cycle registered read and read-before-write.
// Optional feature: define MEM_ARB_RMW_EN to turn partial-strobe stores into
// read-modify-write; otherwise any nonzero strobe writes the full word.
//
// state  | meaning
// IDLE   | accepting at most one request per cycle, round-robin on contention
// RMW_WR | writing merged word of a partial store, no request accepted
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [31:0]       i_addr,
   output logic              i_ready,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_valid,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [3:0]        d_wstrb,
   input  logic [31:0]       d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic [MEM_AW-1:0] mem_address,
   output logic [MEM_DW-1:0] mem_data,
   output logic              mem_wren,
   input  logic [MEM_DW-1:0] mem_q
);

   state_e            state_q, state_d;
   grant_e            last_grant_q, last_grant_d;
   logic              i_rvalid_q, i_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [MEM_AW-1:0] mem_address_q, mem_address_d;
   logic [MEM_AW-1:0] i_word, d_word;
   logic              gnt_i, gnt_d, d_zero, d_part;
   logic              unused_addr_bits;

   assign i_word = i_addr[WORD_LSB +: MEM_AW];
   assign d_word = d_addr[WORD_LSB +: MEM_AW];
   assign unused_addr_bits = ^{i_addr[31:WORD_LSB+MEM_AW], i_addr[WORD_LSB-1:0],
                               d_addr[31:WORD_LSB+MEM_AW], d_addr[WORD_LSB-1:0]};

   // Round-robin: on contention the port not granted most recently wins.
   assign gnt_i = !reset && (state_q == IDLE) && i_valid
                  && (!d_valid || (last_grant_q == GNT_D));
   assign gnt_d = !reset && (state_q == IDLE) && d_valid
                  && (!i_valid || (last_grant_q == GNT_I));
   assign d_zero = (d_wstrb == 4'h0);

`ifdef MEM_ARB_RMW_EN
   logic [MEM_DW-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [MEM_DW-1:0] merged;

   assign d_part = d_we && !d_zero && (d_wstrb != 4'hF);

   mem_byte_merge u_merge (
      .old_word (mem_q),
      .new_word (wdata_q),
      .strb     (wstrb_q),
      .merged   (merged)
   );

   // Partial-store payload held for the write-back cycle.
   always_ff @(posedge clock) begin
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
   end
`else
   assign d_part = 1'b0;
`endif

   // State, grant history, response flags and held memory address.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         last_grant_q  <= GNT_D;
         i_rvalid_q    <= 1'b0;
         d_rvalid_q    <= 1'b0;
         mem_address_q <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         i_rvalid_q    <= i_rvalid_d;
         d_rvalid_q    <= d_rvalid_d;
         mem_address_q <= mem_address_d;
      end
   end

   // Next state: a partial store enters RMW_WR for exactly one cycle.
   always_comb begin
      state_d      = IDLE;
      last_grant_d = last_grant_q;
      if (gnt_i) last_grant_d = GNT_I;
      if (gnt_d) last_grant_d = GNT_D;
      if (gnt_d && d_part) state_d = RMW_WR;
`ifdef MEM_ARB_RMW_EN
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      if (gnt_d && d_part) begin
         wdata_d = d_wdata;
         wstrb_d = d_wstrb;
      end
`endif
   end

   // Memory-side controls and response flags for the current cycle.
   always_comb begin
      mem_address_d = mem_address_q;
      mem_wren      = 1'b0;
      mem_data      = d_wdata;
      i_rvalid_d    = 1'b0;
      d_rvalid_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_i) begin
               mem_address_d = i_word;
               i_rvalid_d    = 1'b1;
            end else if (gnt_d) begin
               if (!d_we) begin
                  mem_address_d = d_word;
                  d_rvalid_d    = 1'b1;
               end else if (!d_zero) begin
                  // A partial store only reads here; the write follows in RMW_WR.
                  mem_address_d = d_word;
                  mem_wren      = !d_part;
               end
            end
         end
`ifdef MEM_ARB_RMW_EN
         RMW_WR: begin
            mem_wren = !reset;
            mem_data = merged;
         end
`endif
         default: ;
      endcase
   end

   assign mem_address = mem_address_d;
   assign i_ready     = gnt_i;
   assign d_ready     = gnt_d;
   assign i_rvalid    = i_rvalid_q;
   assign d_rvalid    = d_rvalid_q;
   assign i_rdata     = mem_q;
   assign d_rdata     = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, transaction-level reference
// model checked every cycle, plus directed literal expectations.
module tb_mem_arbiter;

`ifdef MEM_ARB_RMW_EN
   localparam bit RMW = 1'b1;
`else
   localparam bit RMW = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ready, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_valid = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [3:0]  d_wstrb = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ready, d_rvalid;
   logic [31:0] d_rdata;
   logic [15:0] mem_address;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic [31:0] mem_q = '0;

   logic [31:0] mem_arr [0:65535];
   logic [31:0] ref_mem [0:65535];

   int checks = 0;
   int errors = 0;

   bit          m_last = 1'b1;   // 1: data port granted most recently
   bit          m_busy = 1'b0;
   bit          m_pend_i = 1'b0, m_pend_d = 1'b0;
   logic [31:0] m_pend_i_data, m_pend_d_data, m_rmw_val;
   logic [15:0] m_rmw_word;

   initial forever #5 clock = ~clock;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb),
      .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
      .mem_q(mem_q)
   );

   // Single-port memory: registered read of the pre-write word.
   always @(posedge clock) begin
      mem_q <= mem_arr[mem_address];
      if (mem_wren) mem_arr[mem_address] = mem_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] widx(input logic [31:0] a);
      return 16'(a / 32'd4);
   endfunction

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                       input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~m) | (n & m);
   endfunction

   // Per-cycle comparison against the transaction model, then model advance.
   always @(negedge clock) begin : cmp
      bit          gi, gd, wr, part;
      logic [15:0] wa;
      logic [31:0] wv;
      gi = 1'b0; gd = 1'b0;
      if (!reset && !m_busy) begin
         if (i_valid && d_valid) begin
            gi = m_last;
            gd = !m_last;
         end else begin
            gi = i_valid;
            gd = d_valid;
         end
      end
      part = gd && d_we && (d_wstrb != 4'h0) && (d_wstrb != 4'hF) && RMW;
      wr = 1'b0; wa = '0; wv = '0;
      if (!reset && m_busy) begin
         wr = 1'b1; wa = m_rmw_word; wv = m_rmw_val;
      end else if (gd && d_we && (d_wstrb != 4'h0) && !part) begin
         wr = 1'b1; wa = widx(d_addr); wv = d_wdata;
      end
      chk("i_ready", 32'(i_ready), 32'(gi));
      chk("d_ready", 32'(d_ready), 32'(gd));
      chk("i_rvalid", 32'(i_rvalid), 32'(m_pend_i));
      chk("d_rvalid", 32'(d_rvalid), 32'(m_pend_d));
      if (m_pend_i) chk("i_rdata", i_rdata, m_pend_i_data);
      if (m_pend_d) chk("d_rdata", d_rdata, m_pend_d_data);
      chk("mem_wren", 32'(mem_wren), 32'(wr));
      if (wr) begin
         chk("wr_addr", 32'(mem_address), 32'(wa));
         chk("wr_data", mem_data, wv);
      end
      if (gi) chk("i_rd_addr", 32'(mem_address), 32'(widx(i_addr)));
      if (gd && !d_we) chk("d_rd_addr", 32'(mem_address), 32'(widx(d_addr)));

      if (reset) begin
         m_busy = 1'b0; m_pend_i = 1'b0; m_pend_d = 1'b0; m_last = 1'b1;
      end else begin
         m_pend_i      = gi;
         m_pend_i_data = ref_mem[widx(i_addr)];
         m_pend_d      = gd && !d_we;
         m_pend_d_data = ref_mem[widx(d_addr)];
         if (part) begin
            m_rmw_word = widx(d_addr);
            m_rmw_val  = mrg(ref_mem[widx(d_addr)], d_wdata, d_wstrb);
         end
         if (wr) ref_mem[wa] = wv;
         m_busy = part;
         if (gi || gd) m_last = gd;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 65536; k++) begin
         mem_arr[k] = 32'(k) * 32'h9E37_79B1;
         ref_mem[k] = mem_arr[k];
      end
      mem_arr[16'h0010] = 32'hDEAD_BEEF;
      ref_mem[16'h0010] = 32'hDEAD_BEEF;

      repeat (3) step();
      i_valid = 1'b1; d_valid = 1'b1;
      #2;
      chk("rst_i_ready", 32'(i_ready), 32'd0);
      chk("rst_d_ready", 32'(d_ready), 32'd0);
      chk("rst_wren", 32'(mem_wren), 32'd0);

      // Contention with reads only: I, D, I, D.
      step();
      reset = 1'b0; i_addr = 32'h40; d_addr = 32'h44; d_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("rr_i_grant", 32'(i_ready), 32'(k % 2 == 0));
         chk("rr_d_grant", 32'(d_ready), 32'(k % 2 == 1));
         step();
      end
      i_valid = 1'b0; d_valid = 1'b0;
      #2;
      chk("rr_last_rvalid", 32'(d_rvalid), 32'd1);

      // Fetch, then a wrapped alias of the same word.
      step();
      i_valid = 1'b1; i_addr = 32'h40;
      #2;
      chk("fetch_ready", 32'(i_ready), 32'd1);
      step();
      i_valid = 1'b0;
      #2;
      chk("fetch_rvalid", 32'(i_rvalid), 32'd1);
      chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
      step();
      i_valid = 1'b1; i_addr = 32'hFFFC_0043;
      step();
      i_valid = 1'b0;
      #2;
      chk("wrap_rdata", i_rdata, 32'hDEAD_BEEF);

      // Full store then immediate load of the same word.
      step();
      d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wstrb = 4'hF; d_wdata = 32'h1234_5678;
      #2;
      chk("fs_ready", 32'(d_ready), 32'd1);
      chk("fs_wren", 32'(mem_wren), 32'd1);
      step();
      d_we = 1'b0;
      #2;
      chk("ld_ready", 32'(d_ready), 32'd1);
      step();
      d_valid = 1'b0;
      #2;
      chk("ld_rvalid", 32'(d_rvalid), 32'd1);
      chk("ld_rdata", d_rdata, 32'h1234_5678);

      // Partial store 0x11223344 / 0101 over 0xAABBCCDD, load queued behind it.
      step();
      d_valid = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_wdata = 32'hAABB_CCDD;
      step();
      d_wdata = 32'h1122_3344; d_wstrb = 4'b0101;
      #2;
      chk("ps_ready", 32'(d_ready), 32'd1);
      step();
      d_we = 1'b0;
      #2;
      chk("ps_t1_ready", 32'(d_ready), RMW ? 32'd0 : 32'd1);
      chk("ps_no_rvalid", 32'(d_rvalid), 32'd0);
`ifdef MEM_ARB_RMW_EN
      step();
      #2;
      chk("ps_ld_ready", 32'(d_ready), 32'd1);
      step();
      d_valid = 1'b0;
      #2;
      chk("ps_ld_rvalid", 32'(d_rvalid), 32'd1);
      chk("ps_ld_rdata", d_rdata, 32'hAA22_CC44);
      chk("ps_word", mem_arr[16'h0020], 32'hAA22_CC44);
`else
      step();
      d_valid = 1'b0;
      #2;
      chk("ps_ld_rvalid", 32'(d_rvalid), 32'd1);
      chk("ps_ld_rdata", d_rdata, 32'h1122_3344);
      chk("ps_word", mem_arr[16'h0020], 32'h1122_3344);
`endif

      // Zero-strobe store is accepted and dropped.
      step();
      d_valid = 1'b1; d_we = 1'b1; d_wstrb = 4'h0; d_wdata = 32'hFFFF_FFFF;
      #2;
      chk("zs_ready", 32'(d_ready), 32'd1);
      chk("zs_wren", 32'(mem_wren), 32'd0);
      step();
      d_valid = 1'b0;
      step();
      chk("zs_word", mem_arr[16'h0020], RMW ? 32'hAA22_CC44 : 32'h1122_3344);

      // Reset lands on the write-back cycle of a partial store.
      d_valid = 1'b1; d_we = 1'b1; d_wstrb = 4'b1000; d_wdata = 32'h5500_0000;
      #2;
      chk("rr_ps_ready", 32'(d_ready), 32'd1);
      step();
      d_valid = 1'b0; reset = 1'b1; i_valid = 1'b1; i_addr = 32'h80;
      #2;
      chk("rst_rmw_wren", 32'(mem_wren), 32'd0);
      chk("rst_rmw_i_ready", 32'(i_ready), 32'd0);
      chk("rst_rmw_d_ready", 32'(d_ready), 32'd0);
      chk("rst_rmw_i_rvalid", 32'(i_rvalid), 32'd0);
      chk("rst_rmw_d_rvalid", 32'(d_rvalid), 32'd0);
      step();
      reset = 1'b0;
      #2;
      chk("post_rst_ready", 32'(i_ready), 32'd1);
      step();
      i_valid = 1'b0;
      #2;
      chk("post_rst_rvalid", 32'(i_rvalid), 32'd1);
      chk("post_rst_rdata", i_rdata, RMW ? 32'hAA22_CC44 : 32'h5500_0000);
      chk("post_rst_word", mem_arr[16'h0020], RMW ? 32'hAA22_CC44 : 32'h5500_0000);

      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
